// File: rtl/rgmii_pkg.sv
// rgmii_pkg: speed encodings and per-speed byte/nibble periods for the RGMII PHY source
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam logic [6:0] BYTE_10   = 7'd100;
    localparam logic [6:0] NIB_10    = 7'd50;
    localparam logic [6:0] BYTE_100  = 7'd10;
    localparam logic [6:0] NIB_100   = 7'd5;
    localparam logic [6:0] BYTE_1000 = 7'd1;

    function automatic logic [6:0] byte_period(input logic [1:0] s);
        return (s == SPEED_1000) ? BYTE_1000 : (s == SPEED_100) ? BYTE_100 : BYTE_10;
    endfunction

    // At 1000M there is no nibble split; 1 keeps the high-nibble compare false at cnt 0
    function automatic logic [6:0] nib_period(input logic [1:0] s);
        return (s == SPEED_1000) ? BYTE_1000 : (s == SPEED_100) ? NIB_100 : NIB_10;
    endfunction

    // The reserved encoding 11 runs as 10M
    function automatic logic [1:0] norm_speed(input logic [1:0] s);
        return (s == 2'b11) ? SPEED_10 : s;
    endfunction

endpackage

// File: rtl/rgmii_phase_gen.sv
// rgmii_phase_gen: byte-period counter, capture strobe and per-half RXC levels for the next cycle
module rgmii_phase_gen
    import rgmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_speed,
    input  logic [1:0] i_speed_next,
    output logic       o_clk_en,
    output logic       o_rxc_1,
    output logic       o_rxc_2,
    output logic       o_hi_nib
);

    logic       r_run;
    logic [6:0] r_cnt;
    logic [6:0] w_cnt_next;
    logic [6:0] w_nib;
    logic [6:0] w_mod;
    logic [6:0] w_twice;
    logic       w_wrap;
    logic       w_gig;

    // Strobe on the last cycle of the byte; RXC and nibble select are computed for the cycle after the edge
    always_comb begin
        w_wrap     = r_cnt == byte_period(i_speed) - 7'd1;
        o_clk_en   = r_run && w_wrap;
        w_cnt_next = (!r_run || w_wrap) ? 7'd0 : r_cnt + 7'd1;
        w_nib      = nib_period(i_speed_next);
        w_gig      = i_speed_next == SPEED_1000;
        o_hi_nib   = w_cnt_next >= w_nib;
        w_mod      = o_hi_nib ? w_cnt_next - w_nib : w_cnt_next;
        w_twice    = w_mod + w_mod;
        o_rxc_1    = w_gig || (w_twice < w_nib);
        o_rxc_2    = !w_gig && (w_twice + 7'd1 < w_nib);
    end

    // Counter holds at 0 until the first edge after reset release, then runs and wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_cnt <= 7'd0;
        end else begin
            r_run <= 1'b1;
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/rgmii_phy_source.sv
// rgmii_phy_source: GMII byte stream to RGMII receive-side SDR output pairs at 10/100/1000 Mb/s
module rgmii_phy_source
    import rgmii_pkg::*;
#(
    parameter logic [1:0] DEFAULT_SPEED = 2'b10,
    parameter logic       FULL_DUPLEX   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       link_up,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_clk_en,
    output logic       rgmii_rxc_1,
    output logic       rgmii_rxc_2,
    output logic [3:0] rgmii_rd_1,
    output logic [3:0] rgmii_rd_2,
    output logic       rgmii_rx_ctl_1,
    output logic       rgmii_rx_ctl_2,
    output logic [1:0] active_speed
);

    logic [1:0] r_speed;
    logic [7:0] r_txd;
    logic       r_en;
    logic       r_er;
    logic       r_rxc_1;
    logic       r_rxc_2;
    logic [3:0] r_rd_1;
    logic [3:0] r_rd_2;
    logic       r_ctl_1;
    logic       r_ctl_2;

    logic [1:0] w_speed_next;
    logic [7:0] w_txd;
    logic       w_en;
    logic       w_er;
    logic       w_clk_en;
    logic       w_rxc_1;
    logic       w_rxc_2;
    logic       w_hi_nib;
    logic       w_gig;
    logic [3:0] w_status;
    logic [3:0] w_lo;
    logic [3:0] w_hi;
    logic [3:0] w_rd_1;
    logic [3:0] w_rd_2;

    rgmii_phase_gen u_phase (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_speed      (r_speed),
        .i_speed_next (w_speed_next),
        .o_clk_en     (w_clk_en),
        .o_rxc_1      (w_rxc_1),
        .o_rxc_2      (w_rxc_2),
        .o_hi_nib     (w_hi_nib)
    );

    // Byte and speed in effect after this edge, and the data nibbles (or in-band status) they produce
    always_comb begin
        w_speed_next = (w_clk_en && !gmii_tx_en) ? norm_speed(speed) : r_speed;
        w_txd        = w_clk_en ? gmii_txd : r_txd;
        w_en         = w_clk_en ? gmii_tx_en : r_en;
        w_er         = w_clk_en ? gmii_tx_er : r_er;
        w_gig        = w_speed_next == SPEED_1000;
        w_status     = {FULL_DUPLEX, w_speed_next, link_up};
        w_lo         = (w_en || w_er) ? w_txd[3:0] : w_status;
        w_hi         = (w_en || w_er) ? w_txd[7:4] : w_status;
        w_rd_1       = (!w_gig && w_hi_nib) ? w_hi : w_lo;
        w_rd_2       = (w_gig || w_hi_nib) ? w_hi : w_lo;
    end

    // Byte register, speed latch and registered output pairs; RX_CTL carries en^er while RXC is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_speed <= DEFAULT_SPEED;
            r_txd   <= 8'd0;
            r_en    <= 1'b0;
            r_er    <= 1'b0;
            r_rxc_1 <= 1'b0;
            r_rxc_2 <= 1'b0;
            r_rd_1  <= 4'd0;
            r_rd_2  <= 4'd0;
            r_ctl_1 <= 1'b0;
            r_ctl_2 <= 1'b0;
        end else begin
            r_speed <= w_speed_next;
            r_txd   <= w_txd;
            r_en    <= w_en;
            r_er    <= w_er;
            r_rxc_1 <= w_rxc_1;
            r_rxc_2 <= w_rxc_2;
            r_rd_1  <= w_rd_1;
            r_rd_2  <= w_rd_2;
            r_ctl_1 <= w_rxc_1 ? w_en : w_en ^ w_er;
            r_ctl_2 <= w_rxc_2 ? w_en : w_en ^ w_er;
        end
    end

    assign gmii_clk_en    = w_clk_en;
    assign rgmii_rxc_1    = r_rxc_1;
    assign rgmii_rxc_2    = r_rxc_2;
    assign rgmii_rd_1     = r_rd_1;
    assign rgmii_rd_2     = r_rd_2;
    assign rgmii_rx_ctl_1 = r_ctl_1;
    assign rgmii_rx_ctl_2 = r_ctl_2;
    assign active_speed   = r_speed;

endmodule

// File: tb/tb_rgmii_phy_source.sv
// tb_rgmii_phy_source: vector table, directed corner sequences and a randomized run against a reference model
module tb_rgmii_phy_source;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] speed = 2'b10;
    logic       link_up = 1'b1;
    logic [7:0] gmii_txd = 8'd0;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;
    logic       gmii_clk_en;
    logic       rgmii_rxc_1;
    logic       rgmii_rxc_2;
    logic [3:0] rgmii_rd_1;
    logic [3:0] rgmii_rd_2;
    logic       rgmii_rx_ctl_1;
    logic       rgmii_rx_ctl_2;
    logic [1:0] active_speed;

    int n_checks = 0;
    int n_errs = 0;
    bit chk_on = 1'b0;

    rgmii_phy_source dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .speed          (speed),
        .link_up        (link_up),
        .gmii_txd       (gmii_txd),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_tx_er     (gmii_tx_er),
        .gmii_clk_en    (gmii_clk_en),
        .rgmii_rxc_1    (rgmii_rxc_1),
        .rgmii_rxc_2    (rgmii_rxc_2),
        .rgmii_rd_1     (rgmii_rd_1),
        .rgmii_rd_2     (rgmii_rd_2),
        .rgmii_rx_ctl_1 (rgmii_rx_ctl_1),
        .rgmii_rx_ctl_2 (rgmii_rx_ctl_2),
        .active_speed   (active_speed)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: position within the current byte, the speed in force, the byte on the wire
    bit         m_run = 1'b0;
    int         m_pos = 0;
    logic [1:0] m_speed = 2'b10;
    logic [7:0] m_txd = 8'd0;
    logic       m_en = 1'b0;
    logic       m_er = 1'b0;
    logic       m_link = 1'b0;

    function automatic int bper(input logic [1:0] s);
        return (s == 2'b10) ? 1 : (s == 2'b01) ? 10 : 100;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   <= 1'b0;
            m_pos   <= 0;
            m_speed <= 2'b10;
            m_txd   <= 8'd0;
            m_en    <= 1'b0;
            m_er    <= 1'b0;
            m_link  <= 1'b0;
        end else begin
            m_run  <= 1'b1;
            m_link <= link_up;
            if (m_run && m_pos == bper(m_speed) - 1) begin
                m_pos <= 0;
                m_txd <= gmii_txd;
                m_en  <= gmii_tx_en;
                m_er  <= gmii_tx_er;
                if (!gmii_tx_en) m_speed <= (speed == 2'b11) ? 2'b00 : speed;
            end else if (m_run) begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // {strobe, rxc1, rxc2, rd1, rd2, ctl1, ctl2, speed} expected in the current cycle
    function automatic logic [14:0] model_out();
        int b, n, m;
        logic [3:0] lo, hi, d1, d2;
        logic r1, r2, c1, c2, st;
        if (!m_run) return {13'd0, m_speed};
        b  = bper(m_speed);
        lo = (m_en || m_er) ? m_txd[3:0] : {1'b1, m_speed, m_link};
        hi = (m_en || m_er) ? m_txd[7:4] : {1'b1, m_speed, m_link};
        st = m_pos == b - 1;
        if (b == 1) begin
            r1 = 1'b1; r2 = 1'b0; d1 = lo; d2 = hi;
        end else begin
            n  = b / 2;
            m  = m_pos % n;
            r1 = 2 * m < n;
            r2 = 2 * m + 1 < n;
            d1 = (m_pos < n) ? lo : hi;
            d2 = d1;
        end
        c1 = r1 ? m_en : m_en ^ m_er;
        c2 = r2 ? m_en : m_en ^ m_er;
        return {st, r1, r2, d1, d2, c1, c2, m_speed};
    endfunction

    always @(negedge clk) begin
        if (chk_on)
            chk("cycle", {17'd0, gmii_clk_en, rgmii_rxc_1, rgmii_rxc_2, rgmii_rd_1, rgmii_rd_2,
                          rgmii_rx_ctl_1, rgmii_rx_ctl_2, active_speed}, {17'd0, model_out()});
    end

    // Present a byte and return at the falling edge of the first cycle it is on the outputs
    task automatic send(input logic [7:0] d, input logic e, input logic r);
        int n = 0;
        gmii_txd = d; gmii_tx_en = e; gmii_tx_er = r;
        while (!gmii_clk_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("strobe_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        en;
        logic        er;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int strobes, bad, hi_cnt, n, rst_left;
        for (int i = 0; i < 7; i++) tbl[i] = '{8'h55, 1'b1, 1'b0, {2'b10, 4'h5, 4'h5, 2'b11}};
        tbl[7]  = '{8'hD5, 1'b1, 1'b0, {2'b10, 4'h5, 4'hD, 2'b11}};
        tbl[8]  = '{8'hA5, 1'b1, 1'b0, {2'b10, 4'h5, 4'hA, 2'b11}};
        tbl[9]  = '{8'h77, 1'b0, 1'b0, {2'b10, 4'hD, 4'hD, 2'b00}};
        tbl[10] = '{8'h0F, 1'b0, 1'b1, {2'b10, 4'hF, 4'h0, 2'b01}};
        tbl[11] = '{8'h12, 1'b1, 1'b1, {2'b10, 4'h2, 4'h1, 2'b10}};

        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        chk("reset_outputs", {gmii_clk_en, rgmii_rxc_1, rgmii_rxc_2, rgmii_rd_1, rgmii_rd_2,
                              rgmii_rx_ctl_1, rgmii_rx_ctl_2}, 0);
        chk("reset_speed", active_speed, 2'b10);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_strobe_1000", gmii_clk_en, 1);

        for (int i = 0; i < 12; i++) begin
            gmii_txd = tbl[i].d; gmii_tx_en = tbl[i].en; gmii_tx_er = tbl[i].er;
            @(negedge clk);
            chk($sformatf("gig_vec%0d", i), {rgmii_rxc_1, rgmii_rxc_2, rgmii_rd_1, rgmii_rd_2,
                                             rgmii_rx_ctl_1, rgmii_rx_ctl_2}, tbl[i].exp);
        end

        speed = 2'b01;
        send(8'h00, 1'b0, 1'b0);
        chk("switch_to_100", active_speed, 2'b01);
        send(8'h3C, 1'b1, 1'b0);
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            chk("100m_rxc", {rgmii_rxc_1, rgmii_rxc_2}, {(k % 5) < 3, (k % 5) < 2});
            chk("100m_rd", {rgmii_rd_1, rgmii_rd_2}, (k < 5) ? 8'hCC : 8'h33);
            strobes += int'(gmii_clk_en);
            @(negedge clk);
        end
        chk("100m_strobes", strobes, 1);

        speed = 2'b00; link_up = 1'b1;
        send(8'h00, 1'b0, 1'b0);
        bad = 0; hi_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if ({rgmii_rd_1, rgmii_rd_2} !== 8'h99 || {rgmii_rx_ctl_1, rgmii_rx_ctl_2} !== 2'b00) bad++;
            hi_cnt += int'(rgmii_rxc_1);
            if (k == 0) chk("10m_rxc_start", rgmii_rxc_1, 1);
            if (k == 25) chk("10m_rxc_half", rgmii_rxc_1, 0);
            @(negedge clk);
        end
        chk("10m_status_bad", bad, 0);
        chk("10m_rxc_high", hi_cnt, 50);

        send(8'hAB, 1'b1, 1'b1);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (rgmii_rx_ctl_1 !== rgmii_rxc_1 || rgmii_rx_ctl_2 !== rgmii_rxc_2) bad++;
            if (k == 0) chk("10m_lo_nib", rgmii_rd_1, 4'hB);
            if (k == 50) chk("10m_hi_nib", rgmii_rd_1, 4'hA);
            @(negedge clk);
        end
        chk("10m_err_ctl", bad, 0);

        speed = 2'b01;
        send(8'h11, 1'b1, 1'b0);
        chk("defer_1", active_speed, 2'b00);
        send(8'h22, 1'b1, 1'b0);
        chk("defer_2", active_speed, 2'b00);
        send(8'h00, 1'b0, 1'b0);
        chk("defer_apply", active_speed, 2'b01);
        n = 0;
        while (!gmii_clk_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("new_period_gap", n, 9);

        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset_out", {gmii_clk_en, rgmii_rxc_1, rgmii_rxc_2, rgmii_rd_1, rgmii_rd_2,
                                   rgmii_rx_ctl_1, rgmii_rx_ctl_2}, 0);
        chk("midframe_reset_speed", active_speed, 2'b10);
        speed = 2'b10; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_strobe", gmii_clk_en, 1);
        chk("release_ctl", {rgmii_rxc_1, rgmii_rxc_2, rgmii_rx_ctl_1, rgmii_rx_ctl_2}, 4'b1000);

        rst_left = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            #1;
            gmii_txd   = 8'($urandom_range(0, 255));
            gmii_tx_en = $urandom_range(0, 3) != 0;
            gmii_tx_er = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 150) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 300) == 0) link_up = ~link_up;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 1999) == 0) begin
                rst_n = 1'b0;
                rst_left = 3;
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/rgmii_phy_source.md
# rgmii_phy_source

PHY-side RGMII source: accepts a GMII byte stream and drives the RGMII receive side (RXC, RD, RX_CTL) toward a MAC at 10, 100 or 1000 Mb/s. It is the far end of the MAC's RGMII receive path. It provides loopback and PHY emulation in FPGA test designs, and lets the MAC's clock-based speed detection be exercised in simulation. All outputs are per-half-cycle SDR pairs for external DDR output primitives; the block has no vendor primitives.

## Interface
Parameters:
- DEFAULT_SPEED, 2'b10: active speed after reset (00 = 10M, 01 = 100M, 10 = 1000M).
- FULL_DUPLEX, 1: duplex bit reported in the in-band status nibble.

Ports:
- clk  in  1  125 MHz reference; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- speed  in  2  requested speed; 11 treated as 10.
- link_up  in  1  link bit for in-band status.
- gmii_txd  in  8  byte to send.
- gmii_tx_en  in  1  data valid.
- gmii_tx_er  in  1  error.
- gmii_clk_en  out  1  byte strobe; inputs are captured in cycles where this is high.
- rgmii_rxc_1 / rgmii_rxc_2  out  1 each  RXC level for the first / second half of the cycle.
- rgmii_rd_1 / rgmii_rd_2  out  4 each  RD for the first / second half.
- rgmii_rx_ctl_1 / rgmii_rx_ctl_2  out  1 each  RX_CTL for the first / second half.
- active_speed  out  2  speed currently in effect.

## Operation
- Byte period B: 1 cycle at 1000M, 10 at 100M, 100 at 10M.
- Nibble period N = B/2 cycles at 10M and 100M, so N = 50 or 5.
- Counter cnt runs 0..B-1 and wraps.
- gmii_clk_en is high when cnt == B-1. At 1000M it is high every cycle.
- On the capture edge, the block latches the byte register {txd, en, er}. The new byte starts at cnt == 0.
- 1000M:
  - rxc_1 = 1, rxc_2 = 0.
  - rd_1 = byte[3:0], rd_2 = byte[7:4].
- 10M and 100M: a half-cycle phase h = 2*(cnt mod N) + half (0 or 1).
  - RXC is high for h < N and low otherwise, giving a 50% duty cycle. At 100M, cycle 2 of each nibble has rxc_1 = 1 and rxc_2 = 0.
  - RD holds byte[3:0] for the first nibble period (cnt < N) and byte[7:4] for the second.
- RX_CTL, for each half: RXC high → en; RXC low → en ^ er.
- In-band status: when en = 0 and er = 0, RD = {FULL_DUPLEX, active_speed, link_up} in place of data.
- Speed changes:
  - active_speed loads `speed` only on a capture edge where gmii_tx_en = 0. A change requested mid-frame is deferred until the first idle capture.
  - On a speed change, cnt restarts at 0 with the new B.
- Reset mid-frame: all state clears immediately and no partial nibble is emitted after release. The MAC sees the frame truncated (RX_CTL low).

## Timing
- Reset values:
  - gmii_clk_en = 0.
  - All rxc, rd and rx_ctl outputs = 0.
  - active_speed = DEFAULT_SPEED.
  - cnt = 0; byte register = idle.
- Clock outputs start in the first cycle after rst_n rises. The first gmii_clk_en occurs at cnt == B-1 of the first period.
- Latency: a byte captured in cycle C (gmii_clk_en high) appears on the outputs from cycle C+1. The output pairs are registered.
- The byte register holds between strobes. The input is not sampled outside gmii_clk_en.
- A rising speed edge and a capture in the same cycle: the capture uses the old B, and the new B applies from the next cnt == 0.
- Counter width is 7 bits. No other arithmetic.

## Structure
- Package rgmii_pkg holds:
  - the speed encodings SPEED_10/100/1000;
  - per-speed byte-period and nibble-period constants (100/50, 10/5, 1/-).
- Sub-module rgmii_phase_gen contains cnt, the wrap logic, gmii_clk_en and the per-half RXC levels. It takes active_speed as input.
- The top level holds the byte register, the speed latch, nibble/status muxing and the output registers.

## Test plan
- 1000M: send bytes 0x55 x7, 0xD5, 0xA5 with en = 1 → each output cycle rxc_1/2 = 1/0; rd_1/rd_2 = 5/5 …, 5/D, 5/A; ctl_1 = ctl_2 = 1.
- 100M: reset with speed = 01, one byte 0x3C → rxc is high for 5 halves and low for 5 halves. rd = C for 5 cycles, then 3 for 5 cycles. gmii_clk_en is high once per 10 cycles.
- 10M idle with link_up = 1 → rd = 4'b1001 constant, ctl = 0, RXC period 50 cycles. Next, en = 1 and er = 1 → ctl = 1 while RXC is high and 0 while RXC is low.
- Switch speed from 10 to 01 mid-frame → active_speed stays 10 until the first byte with en = 0 is captured. Then the period becomes 10 cycles, starting at cnt = 0.
- Assert rst_n low during byte 3 of a 100M frame → all outputs read 0 asynchronously. After release: active_speed = DEFAULT_SPEED, and the first strobe falls at cnt == B-1.
